vga_sync_gen: RTL and testbench
===============================

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 SHALL expose parameter H_VISIBLE, default 640, active pixels per line.
REQ-002 SHALL expose parameter H_FRONT, default 16, horizontal front-porch pixels.
REQ-003 SHALL expose parameter H_SYNC, default 96, hsync pulse width in pixels.
REQ-004 SHALL expose parameter H_BACK, default 48, horizontal back-porch pixels (line total 800).
REQ-005 SHALL expose parameters V_VISIBLE 480, V_FRONT 10, V_SYNC 2, V_BACK 33, vertical equivalents in lines (frame total 525).
REQ-006 SHALL have port Clock, input, 1, system clock; single clock domain.
REQ-007 SHALL have port Reset, input, 1, synchronous, active-high reset.
REQ-008 SHALL have port xpos, output, 10, current pixel column, 0..799.
REQ-009 SHALL have port ypos, output, 10, current line, 0..524.
REQ-010 SHALL have port hsync, output, 1, horizontal sync, active low.
REQ-011 SHALL have port vsync, output, 1, vertical sync, active low.
REQ-012 SHALL have port visible, output, 1, high when xpos<640 and ypos<480.
REQ-013 SHALL have port pixel_tick, output, 1, one-Clock pulse marking each pixel advance.
REQ-014 SHALL have port frame_done, output, 1, one-Clock pulse on the wrap from (799,524) to (0,0).

Function
REQ-015 SHALL advance xpos by 1 on every Clock where pixel_tick is high; otherwise hold all counters.
REQ-016 SHALL wrap xpos 799->0 and, in the same cycle, increment ypos.
REQ-017 SHALL wrap ypos 524->0 when xpos wraps on line 524; frame_done SHALL pulse in that same cycle.
REQ-018 SHALL drive hsync low exactly while xpos is in 656..751 (H_VISIBLE+H_FRONT .. +H_SYNC-1), high otherwise.
REQ-019 SHALL drive vsync low exactly while ypos is in 490..491, high otherwise.
REQ-020 SHALL register hsync, vsync, and visible from next-state counter values so that they are cycle-aligned with the registered xpos/ypos (zero relative skew).
REQ-021 SHALL hold each (xpos,ypos) value for exactly one pixel_tick period, so that a downstream test xpos==0 && ypos==480 is true for exactly one pixel period per frame.
REQ-022 SHALL size all counter comparisons to 10 bits; there SHALL be no counter value outside 0..799 / 0..524.

Reset
REQ-023 While Reset is high at a Clock edge, SHALL load xpos=0, ypos=0, hsync=1, vsync=1, visible=1, pixel_tick=0, frame_done=0, and pixel divider=0.
REQ-024 Reset asserted mid-frame SHALL take effect on the next edge regardless of pixel_tick; no partial line completes.
REQ-025 After Reset deasserts, the first counter advance SHALL follow REQ-027/REQ-028 timing from divider=0.

Configuration
REQ-026 SHALL support macro VGA_PIXDIV_EN.
REQ-027 With VGA_PIXDIV_EN defined: SHALL contain a 2-bit divider; pixel_tick SHALL be high for one Clock when the divider equals 3 (one tick per 4 Clocks, 25 MHz from 100 MHz); first tick on the 4th edge after Reset release.
REQ-028 Without VGA_PIXDIV_EN: pixel_tick SHALL be constant high after reset (Clock is the pixel clock); the divider SHALL not be instantiated.

Structure
REQ-029 SHALL place the H_*/V_* defaults, derived totals (H_TOTAL 800, V_TOTAL 525), and sync start/end constants in shared package vga_timing_pkg, reused by downstream game and overlay blocks.
REQ-030 SHALL implement the pixel divider as sub-module pix_tick_div (Clock, Reset, tick out), instantiated only under VGA_PIXDIV_EN.

Verification
REQ-031 Reset held 3 Clocks then released (divider build) -> xpos=0/ypos=0/hsync=1/vsync=1; first xpos=1 appears 4 Clocks after release, pixel_tick spacing exactly 4.
REQ-032 Run one full line -> hsync low for exactly 96 pixel ticks starting at xpos=656; xpos 799->0 coincides with ypos 0->1.
REQ-033 Run one full frame -> vsync low for exactly 2 lines (ypos 490,491) = 1600 pixel ticks; frame_done pulses once, at wrap 524/799->0/0; 420000 ticks per frame.
REQ-034 Sample visible across a frame -> high count = 307200 ticks; low at xpos=640 and at ypos=480.
REQ-035 Assert Reset at xpos=300, ypos=200 for one Clock -> next cycle xpos=0, ypos=0, hsync=vsync=1, no frame_done pulse.
REQ-036 Non-divider build -> pixel_tick constantly high; xpos increments every Clock; xpos==0 && ypos==480 true for exactly one Clock per frame.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants and helpers, used by the sync generator
// and by downstream game/overlay blocks that need the same screen geometry.
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int H_TOTAL       = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;
    localparam int V_TOTAL       = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    // Sync windows are half-open: [start, end).
    localparam int H_SYNC_START = H_VISIBLE_DEF + H_FRONT_DEF;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF;
    localparam int V_SYNC_START = V_VISIBLE_DEF + V_FRONT_DEF;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF;

    function automatic logic in_window(
        input logic [CNT_W-1:0] value,
        input logic [CNT_W-1:0] lo,
        input logic [CNT_W-1:0] hi
    );
        return (value >= lo) && (value < hi);
    endfunction

endpackage

// File: rtl/pix_tick_div.sv
// Divide-by-4 pixel strobe: one-Clock tick every fourth Clock (100 MHz -> 25 MHz).
// Only present in builds that define VGA_PIXDIV_EN.
`ifdef VGA_PIXDIV_EN
module pix_tick_div (
    input  logic Clock,
    input  logic Reset,
    output logic tick
);

    logic [1:0] div_q;
    logic [1:0] div_d;

    // Free-running divider next state.
    always_comb begin
        div_d = div_q + 2'd1;
    end

    // Divider register; restarts from zero on reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            div_q <= 2'd0;
        end else begin
            div_q <= div_d;
        end
    end

    assign tick = (div_q == 2'd3);

endmodule
`endif

// File: rtl/vga_sync_gen.sv
// VGA sync generator: pixel/line counters with registered, zero-skew sync and blanking.
// Build option VGA_PIXDIV_EN: derive the pixel strobe from Clock/4 instead of every Clock.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF
) (
    input  logic             Clock,
    input  logic             Reset,
    output logic [CNT_W-1:0] xpos,
    output logic [CNT_W-1:0] ypos,
    output logic             hsync,
    output logic             vsync,
    output logic             visible,
    output logic             pixel_tick,
    output logic             frame_done
);

    localparam logic [CNT_W-1:0] H_LAST_C   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [CNT_W-1:0] V_LAST_C   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [CNT_W-1:0] H_VIS_C    = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS_C    = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_START_C = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END_C   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START_C = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END_C   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

    logic             tick_s;
    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] y_q, y_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             vis_q, vis_d;
    logic             fd_q, fd_d;

`ifdef VGA_PIXDIV_EN
    pix_tick_div u_pix_tick_div (
        .Clock (Clock),
        .Reset (Reset),
        .tick  (tick_s)
    );
`else
    logic tick_q;

    // Clock is the pixel clock: strobe is low only while in reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= 1'b1;
        end
    end

    assign tick_s = tick_q;
`endif

    // Counter next state; sync/blank are decoded from the next-state position so they
    // land in the same register stage as xpos/ypos.
    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        fd_d = 1'b0;
        if (tick_s) begin
            if (x_q == H_LAST_C) begin
                x_d = '0;
                if (y_q == V_LAST_C) begin
                    y_d  = '0;
                    fd_d = 1'b1;
                end else begin
                    y_d = y_q + 10'd1;
                end
            end else begin
                x_d = x_q + 10'd1;
            end
        end else begin
            x_d = x_q;
            y_d = y_q;
        end
        hs_d  = ~in_window(x_d, HS_START_C, HS_END_C);
        vs_d  = ~in_window(y_d, VS_START_C, VS_END_C);
        vis_d = (x_d < H_VIS_C) && (y_d < V_VIS_C);
    end

    // Position and timing registers; reset wins over any pending advance.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            x_q   <= '0;
            y_q   <= '0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            vis_q <= 1'b1;
            fd_q  <= 1'b0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            vis_q <= vis_d;
            fd_q  <= fd_d;
        end
    end

    assign xpos       = x_q;
    assign ypos       = y_q;
    assign hsync      = hs_q;
    assign vsync      = vs_q;
    assign visible    = vis_q;
    assign pixel_tick = tick_s;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: full-size instance for reset/line timing, reduced-geometry instance
// (30x17 total) for whole-frame, vsync and mid-frame reset behaviour.
module tb_vga_sync_gen;

`ifdef VGA_PIXDIV_EN
    localparam int SP    = 4;
    localparam int FIRST = 4;
`else
    localparam int SP    = 1;
    localparam int FIRST = 2;
`endif

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [9:0] d_xpos, d_ypos, s_xpos, s_ypos;
    logic       d_hsync, d_vsync, d_visible, d_tick, d_fd;
    logic       s_hsync, s_vsync, s_visible, s_tick, s_fd;
    int         checks = 0;
    int         errors = 0;

    always #5 Clock = ~Clock;

    vga_sync_gen u_dut (
        .Clock(Clock), .Reset(Reset), .xpos(d_xpos), .ypos(d_ypos),
        .hsync(d_hsync), .vsync(d_vsync), .visible(d_visible),
        .pixel_tick(d_tick), .frame_done(d_fd)
    );

    vga_sync_gen #(
        .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
        .V_VISIBLE(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) u_small (
        .Clock(Clock), .Reset(Reset), .xpos(s_xpos), .ypos(s_ypos),
        .hsync(s_hsync), .vsync(s_vsync), .visible(s_visible),
        .pixel_tick(s_tick), .frame_done(s_fd)
    );

    task automatic test_reset();
        int lat = 0;
        int last = -1;
        int ngap = 0;
        Reset = 1'b1;
        repeat (3) @(negedge Clock);
        checks += 7;
        if (d_xpos !== 10'd0) begin errors++; $display("FAIL rst_xpos got %0d expected 0", d_xpos); end
        if (d_ypos !== 10'd0) begin errors++; $display("FAIL rst_ypos got %0d expected 0", d_ypos); end
        if (d_hsync !== 1'b1) begin errors++; $display("FAIL rst_hsync got %b expected 1", d_hsync); end
        if (d_vsync !== 1'b1) begin errors++; $display("FAIL rst_vsync got %b expected 1", d_vsync); end
        if (d_visible !== 1'b1) begin errors++; $display("FAIL rst_visible got %b expected 1", d_visible); end
        if (d_tick !== 1'b0) begin errors++; $display("FAIL rst_tick got %b expected 0", d_tick); end
        if (d_fd !== 1'b0) begin errors++; $display("FAIL rst_frame_done got %b expected 0", d_fd); end
        Reset = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge Clock);
            if (d_xpos == 10'd1 && lat == 0) lat = i;
        end
        checks++;
        if (lat != FIRST) begin errors++; $display("FAIL first_advance got %0d expected %0d", lat, FIRST); end
        for (int i = 0; i < 40; i++) begin
            @(negedge Clock);
            if (d_tick === 1'b1) begin
                if (last >= 0 && ngap < 3) begin
                    checks++;
                    ngap++;
                    if (i - last != SP) begin errors++; $display("FAIL tick_spacing got %0d expected %0d", i - last, SP); end
                end
                last = i;
            end
        end
    endtask

    task automatic test_line();
        int hs_low = 0;
        int first_low = -1;
        logic [9:0] px = d_xpos;
        logic [9:0] py = d_ypos;
        bit wrapped = 0;
        for (int i = 0; i < 900 * SP && !wrapped; i++) begin
            @(negedge Clock);
            if (d_hsync === 1'b0) begin
                hs_low++;
                if (first_low < 0) first_low = int'(d_xpos);
            end
            if (d_xpos == 10'd640 && px == 10'd639) begin
                checks++;
                if (d_visible !== 1'b0) begin errors++; $display("FAIL vis_x640 got %b expected 0", d_visible); end
            end
            if (d_xpos == 10'd639 && px == 10'd638) begin
                checks++;
                if (d_visible !== 1'b1) begin errors++; $display("FAIL vis_x639 got %b expected 1", d_visible); end
            end
            if (px == 10'd799 && d_xpos == 10'd0) begin
                wrapped = 1;
                checks++;
                if (d_ypos !== py + 10'd1 || py !== 10'd0) begin
                    errors++; $display("FAIL line_wrap_y got %0d expected 1", d_ypos);
                end
            end
            px = d_xpos;
            py = d_ypos;
        end
        checks += 3;
        if (!wrapped) begin errors++; $display("FAIL line_wrap_seen got 0 expected 1"); end
        if (first_low != 656) begin errors++; $display("FAIL hsync_start got %0d expected 656", first_low); end
        if (hs_low != 96 * SP) begin errors++; $display("FAIL hsync_width got %0d expected %0d", hs_low, 96 * SP); end
    endtask

    task automatic test_frame();
        int vis_t = 0, vs_t = 0, hs_t = 0, org_t = 0, org_raw = 0, fd_at = -1;
        int vs_first = -1;
        logic [9:0] px = 10'd0, py = 10'd0;
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        for (int i = 1; i <= 600 * SP + 10 && fd_at < 0; i++) begin
            @(negedge Clock);
            if (s_fd === 1'b1) begin
                fd_at = i;
                checks += 3;
                if (s_xpos !== 10'd0 || s_ypos !== 10'd0) begin
                    errors++; $display("FAIL fd_pos got %0d,%0d expected 0,0", s_xpos, s_ypos);
                end
                if (px !== 10'd29 || py !== 10'd16) begin
                    errors++; $display("FAIL fd_prev got %0d,%0d expected 29,16", px, py);
                end
                if (i != FIRST + 509 * SP) begin errors++; $display("FAIL frame_len got %0d expected %0d", i, FIRST + 509 * SP); end
            end else begin
                if (s_xpos == 10'd0 && s_ypos == 10'd10) org_raw++;
                if (s_tick === 1'b1) begin
                    if (s_visible === 1'b1) vis_t++;
                    if (s_vsync === 1'b0) begin
                        vs_t++;
                        if (vs_first < 0) vs_first = int'(s_ypos);
                    end
                    if (s_hsync === 1'b0) hs_t++;
                    if (s_xpos == 10'd0 && s_ypos == 10'd10) org_t++;
                end
            end
            px = s_xpos;
            py = s_ypos;
        end
        checks += 8;
        if (fd_at < 0) begin errors++; $display("FAIL frame_done_seen got 0 expected 1"); end
        if (vis_t != 160) begin errors++; $display("FAIL visible_ticks got %0d expected 160", vis_t); end
        if (vs_t != 60) begin errors++; $display("FAIL vsync_ticks got %0d expected 60", vs_t); end
        if (vs_first != 12) begin errors++; $display("FAIL vsync_start got %0d expected 12", vs_first); end
        if (hs_t != 102) begin errors++; $display("FAIL hsync_ticks got %0d expected 102", hs_t); end
        if (org_t != 1) begin errors++; $display("FAIL origin_ticks got %0d expected 1", org_t); end
        if (org_raw != SP) begin errors++; $display("FAIL origin_clocks got %0d expected %0d", org_raw, SP); end
        @(negedge Clock);
        if (s_fd !== 1'b0) begin errors++; $display("FAIL fd_width got %b expected 0", s_fd); end
    endtask

    task automatic test_mid_reset();
        bit hit = 0;
        for (int i = 0; i < 600 * SP && !hit; i++) begin
            @(negedge Clock);
            if (s_xpos == 10'd21 && s_ypos == 10'd12) hit = 1;
        end
        checks += 3;
        if (!hit) begin errors++; $display("FAIL mid_reach got 0 expected 1"); end
        if (s_hsync !== 1'b0) begin errors++; $display("FAIL mid_hsync_low got %b expected 0", s_hsync); end
        if (s_vsync !== 1'b0) begin errors++; $display("FAIL mid_vsync_low got %b expected 0", s_vsync); end
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        checks += 5;
        if (s_xpos !== 10'd0 || s_ypos !== 10'd0) begin
            errors++; $display("FAIL mid_rst_pos got %0d,%0d expected 0,0", s_xpos, s_ypos);
        end
        if (s_hsync !== 1'b1) begin errors++; $display("FAIL mid_rst_hsync got %b expected 1", s_hsync); end
        if (s_vsync !== 1'b1) begin errors++; $display("FAIL mid_rst_vsync got %b expected 1", s_vsync); end
        if (s_fd !== 1'b0) begin errors++; $display("FAIL mid_rst_fd got %b expected 0", s_fd); end
        if (s_visible !== 1'b1) begin errors++; $display("FAIL mid_rst_visible got %b expected 1", s_visible); end
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
